// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the timer_arbiter block.
package timer_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate the request vector so the search
// starts just after the last grant, priority-encode, then rotate the index back.
module rr_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = owner_w(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last_grant,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_grant_idx,
    output logic         o_any_grant
);

    logic [N-1:0] w_rot;
    int           w_start;
    int           w_enc;
    int           w_sum;

    always_comb begin
        w_start = (int'(i_last_grant) >= N - 1) ? 0 : int'(i_last_grant) + 1;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = i_req[(j + w_start) % N];
        end
        // Lowest set bit of the rotated vector is the nearest requester.
        w_enc = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) w_enc = j;
        end
        w_sum = w_enc + w_start;
        if (w_sum >= N) w_sum = w_sum - N;
        o_any_grant = |i_req;
        o_grant_idx = W'(w_sum);
        o_grant     = '0;
        if (o_any_grant) o_grant[w_sum] = 1'b1;
    end

endmodule

// File: rtl/timer_arbiter.sv
// One down-counter shared by NUM_REQ requesters: round-robin grant of a
// programmed interval, one-cycle done pulse to the owner when it expires.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*CNT_W-1:0]     req_count,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [owner_w(NUM_REQ)-1:0]  owner
);

    localparam int OW = owner_w(NUM_REQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      w_owner_nxt;
    logic [OW-1:0]      r_last_grant;
    logic [OW-1:0]      w_last_nxt;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic [NUM_REQ-1:0] w_ready;

    logic [NUM_REQ-1:0] w_grant;
    logic [OW-1:0]      w_grant_idx;
    logic               w_any;
    logic [CNT_W-1:0]   w_win_cnt;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (OW)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any_grant  (w_any)
    );

    assign w_win_cnt = req_count[int'(w_grant_idx)*CNT_W +: CNT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_owner      <= '0;
            r_last_grant <= OW'(NUM_REQ - 1);
            r_done       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_nxt;
            r_done       <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_grant;
        w_done_nxt  = '0;
        w_ready     = '0;
        case (r_state)
            IDLE: begin
                // The winner is always a valid requester, so ready implies handshake.
                if (w_any) begin
                    w_ready     = w_grant;
                    w_cnt_nxt   = w_win_cnt;
                    w_owner_nxt = w_grant_idx;
                    w_last_nxt  = w_grant_idx;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_done_nxt[r_owner] = 1'b1;
                    w_state_nxt         = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset is asynchronous, so ready must drop with it rather than at the next edge.
    assign req_ready = rst ? '0 : w_ready;
    assign done      = r_done;
    assign busy      = (r_state == RUN);
    assign owner     = r_owner;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a cycle-indexed behavioural model.
module tb_timer_arbiter;

    localparam int N  = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*CW-1:0] req_count = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    done;
    logic            busy;
    logic [1:0]      owner;

    timer_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_count (req_count),
        .req_ready (req_ready),
        .done      (done),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each granted interval is a set of absolute cycle numbers.
    int           cyc        = 0;
    int           m_lo       = 1;
    int           m_hi       = 0;
    int           m_done_cyc = -1;
    int           m_done_who = 0;
    int           m_owner    = 0;
    int           m_last     = N - 1;
    int           m_w;
    int           m_c;
    bit           m_busy;
    logic [N-1:0] m_rdy;
    logic [N-1:0] m_done;
    logic [N-1:0] one = 1;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_lo = 1; m_hi = 0; m_done_cyc = -1; m_done_who = 0;
            m_owner = 0; m_last = N - 1;
        end else begin
            m_busy = (cyc >= m_lo) && (cyc <= m_hi);
            m_done = (cyc == m_done_cyc) ? (one << m_done_who) : '0;
            m_w    = m_busy ? -1 : rr_pick(req_valid, m_last);
            m_rdy  = (m_w >= 0) ? (one << m_w) : '0;
            chk("model_busy",  32'(busy),      32'(m_busy));
            chk("model_done",  32'(done),      32'(m_done));
            chk("model_ready", 32'(req_ready), 32'(m_rdy));
            chk("model_owner", 32'(owner),     32'(m_owner));
            if (m_w >= 0) begin
                m_c        = int'(req_count[m_w*CW +: CW]);
                m_lo       = cyc + 1;
                m_hi       = cyc + m_c + 1;
                m_done_cyc = cyc + m_c + 2;
                m_done_who = m_w;
                m_owner    = m_w;
                m_last     = m_w;
            end
        end
    end

    logic [N-1:0] hs_q = '0;
    always @(posedge clk) hs_q <= req_valid & req_ready;

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; req_count = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Called just after the handshake edge; n is the cycle index of the done pulse.
    task automatic wait_done(input int bound, output int n, output int nbusy, output logic [N-1:0] d);
        n = 0; nbusy = 0; d = '0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
            if (done != '0) begin
                d = done;
                break;
            end
        end
        if (d == '0) chk("done_timeout", 32'(n), 32'(0));
    endtask

    function automatic logic [CW-1:0] rand_cnt();
        return ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 6));
    endfunction

    int           n, nb;
    logic [N-1:0] d;
    logic [N-1:0] acc;
    int           dcount;

    initial begin
        // Single requester 2, count 5
        do_reset();
        chk("reset_busy",  32'(busy),  32'(0));
        chk("reset_owner", 32'(owner), 32'(0));
        chk("reset_done",  32'(done),  32'(0));
        req_valid = 4'b0100; req_count[2*CW +: CW] = 16'd5;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1; req_valid = '0;
        wait_done(50, n, nb, d);
        chk("t1_done_cycle", 32'(n), 32'd7);
        chk("t1_busy_cycles", 32'(nb), 32'd6);
        chk("t1_done_vec", 32'(d), 32'h4);
        chk("t1_owner", 32'(owner), 32'd2);

        // All four valid with count 0, held valid
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < N * CW; k++) req_count[k] = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("t2_ready", 32'(req_ready), (k % 2 == 0) ? 32'(1 << ((k / 2) % 4)) : 32'd0);
            chk("t2_done",  32'(done), (k >= 2 && k % 2 == 0) ? 32'(1 << (((k / 2) - 1) % 4)) : 32'd0);
        end
        @(posedge clk); #1; req_valid = '0;

        // Requester 1 running while 0 and 3 arrive
        do_reset();
        req_valid = 4'b0010; req_count[1*CW +: CW] = 16'd3;
        @(posedge clk); #1;
        req_valid = 4'b1001; req_count[0 +: CW] = 16'd1; req_count[3*CW +: CW] = 16'd1;
        acc = '0; d = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done != '0) begin d = done; break; end
            acc |= req_ready;
        end
        chk("t3_ready_in_run", 32'(acc), 32'd0);
        chk("t3_done_req1", 32'(d), 32'h2);
        chk("t3_next_grant", 32'(req_ready), 32'h8);
        @(posedge clk); #1; req_valid = 4'b0001;
        acc = '0;
        for (int k = 0; k < 20 && acc == '0; k++) begin
            @(negedge clk);
            acc = req_ready;
        end
        chk("t3_then_grant", 32'(acc), 32'h1);
        @(posedge clk); #1; req_valid = '0;

        // Requester 3 withdraws before being granted
        do_reset();
        req_valid = 4'b0010; req_count[1*CW +: CW] = 16'd4;
        @(posedge clk); #1;
        req_valid = 4'b1000; req_count[3*CW +: CW] = 16'd2;
        @(posedge clk); @(posedge clk); #1;
        req_valid = '0;
        acc = '0; dcount = 0; d = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acc |= req_ready;
            d   |= done;
            if (done[1]) dcount++;
        end
        chk("t6_no_grant3", 32'(acc[3]), 32'd0);
        chk("t6_no_done3",  32'(d[3]),   32'd0);
        chk("t6_done1_once", 32'(dcount), 32'd1);

        // Reset in the middle of a count-10 interval
        do_reset();
        req_valid = 4'b0100; req_count[2*CW +: CW] = 16'd10;
        @(posedge clk); #1; req_valid = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        chk("t4_busy_now",  32'(busy),      32'd0);
        chk("t4_ready_now", 32'(req_ready), 32'd0);
        chk("t4_owner_now", 32'(owner),     32'd0);
        chk("t4_done_now",  32'(done),      32'd0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst = 1'b0;
        d = '0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            d |= done;
        end
        chk("t4_no_done", 32'(d), 32'd0);
        @(posedge clk); #1; req_valid = 4'b1111;
        @(negedge clk);
        chk("t4_first_prio", 32'(req_ready), 32'h1);
        @(posedge clk); #1; req_valid = '0;

        // Maximum count on requester 0
        do_reset();
        req_valid = 4'b0001; req_count[0 +: CW] = 16'hFFFF;
        @(posedge clk); #1; req_valid = '0;
        wait_done(70000, n, nb, d);
        chk("t5_done_cycle", 32'(n), 32'd65537);
        chk("t5_busy_cycles", 32'(nb), 32'd65536);
        chk("t5_done_vec", 32'(d), 32'h1);

        // Randomized traffic
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if (hs_q[i]) begin
                        if ($urandom_range(0, 1) == 1) req_count[i*CW +: CW] = rand_cnt();
                        else req_valid[i] = 1'b0;
                    end else if ($urandom_range(0, 7) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_count[i*CW +: CW] = rand_cnt();
                end
            end
        end
        @(posedge clk); #1; req_valid = '0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares a single down-counter timing resource among NUM_REQ requesters. Each requester hands over a cycle count via a valid/ready handshake. A round-robin arbiter grants the counter. The block pulses that requester's done line when the interval expires. It sits between client FSMs that need programmable delays and the one physical counter, replacing per-client counter instances.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- CNT_W, 16, width of each requested count
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request strobe
- req_count  in  NUM_REQ*CNT_W  packed counts, requester i at bits [i*CNT_W +: CNT_W]
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready at a rising edge
- done  out  NUM_REQ  one-hot, one-cycle pulse when the granted interval expires
- busy  out  1  high while the counter is owned (RUN state)
- owner  out  $clog2(NUM_REQ)  index of the current/last owner

## Operation
- FSM states: IDLE, RUN (enum in package).
- IDLE:
  - If any req_valid is high, the arbiter selects one winner. Search starts at last_grant+1 and wraps modulo NUM_REQ.
  - req_ready is asserted combinationally for the winner only. All other req_ready bits are 0.
  - At the handshake edge: cnt <= winner's req_count, owner <= winner, last_grant <= winner, state <= RUN.
- RUN:
  - req_ready is all zeros.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: done[owner] <= 1 for one cycle, state <= IDLE.
- Requester rules:
  - Once raised, req_valid and req_count must stay stable until the handshake.
  - Dropping req_valid before the grant is legal: that requester is simply skipped. No state is kept for it.
- A requester may re-request in the same cycle its done pulse is high. It is arbitrated normally, so it is not favored over waiting requesters.
- Count arithmetic: an unsigned CNT_W-bit count with no overflow path. cnt only decrements and stops at 0.
- Reset values:
  - state=IDLE, cnt=0, owner=0, last_grant=NUM_REQ-1 (requester 0 has first priority after reset).
  - done=0, busy=0, req_ready=0 (rst forces ready low).
- Reset mid-RUN: the interval is abandoned and no done pulse is emitted. Reset is asynchronous, so all outputs clear immediately.

## Timing
- Handshake at edge E0 with count C: busy is high from E0 to E(C+1).
- done[i] is high for exactly the one cycle following edge E(C+1), i.e. C+1 cycles after the handshake.
- C=0 gives a done pulse one cycle after the handshake.
- busy drops in the same cycle done is high. The block is in IDLE then, so the next grant can handshake at the edge ending the done cycle.
- Back-to-back throughput: one grant every C+2 cycles.
- Single requester continuously valid: granted again immediately after each done.
- req_ready depends combinationally on req_valid and state only, never on req_count.
- All other outputs are registered.

## Structure
- Package timer_arbiter_pkg:
  - state_t enum {IDLE, RUN}.
  - Function computing the owner width ($clog2 with a minimum of 1).
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req vector, last_grant index.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational rotate-priority-encode-unrotate.
- Top level holds the FSM, the counter, and the owner/last_grant/done registers.

## Test plan
- Reset, then only req 2 valid with count 5, handshake at E0 -> req_ready=4'b0100 in that cycle; busy high E0..E6; done=4'b0100 one cycle after E6; owner=2.
- All four valid with count 0, held valid -> grant order 0,1,2,3,0; each done 1 cycle after its handshake; grants 2 cycles apart.
- req 1 count 3 in RUN, reqs 0 and 3 raise valid meanwhile -> req_ready stays 0 during RUN; next grant goes to 3 (search starts after 1), then 0.
- Assert rst at E2 during a count-10 interval -> done never pulses; busy, req_ready and owner are 0 immediately; after release, req 0 has first priority.
- Count 16'hFFFF on req 0 -> done exactly 65536 cycles after the handshake; no wrap.
- req 3 drops valid before being granted while req 1 owns the counter -> req 3 is never granted and never gets done; no stale pulse.
